branch_seq_ctrl: RTL

//  Control sequencer for conditional-branch instructions (brzr/brnz/brpl/brmi) in the CPU datapath.

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/branch_stat_counters.sv | 29 ++
 rtl/branch_seq_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer state encoding, opcodes and
// branch condition codes.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_DONE = 4'd8,
      ST_ERR  = 4'd9
   } state_e;

   // IR[31:27] opcodes
   localparam logic [4:0] OP_LD     = 5'b00000;
   localparam logic [4:0] OP_ST     = 5'b00010;
   localparam logic [4:0] BR_OPCODE = 5'b10010;

   // IR[20:19] branch conditions (evaluated by the CON flip-flop)
   localparam logic [1:0] COND_ZR = 2'b00;
   localparam logic [1:0] COND_NZ = 2'b01;
   localparam logic [1:0] COND_PL = 2'b10;
   localparam logic [1:0] COND_MI = 2'b11;

endpackage

// File: rtl/branch_stat_counters.sv
// Saturating taken / not-taken branch counters, cleared only by reset.
module branch_stat_counters (
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic        evt_i,
   input  logic        taken_i,
   output logic [15:0] taken_cnt_o,
   output logic [15:0] not_taken_cnt_o
);

   logic [15:0] taken_cnt_q, not_taken_cnt_q;

   // count one resolved branch per event, holding at all-ones
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         taken_cnt_q     <= '0;
         not_taken_cnt_q <= '0;
      end else if (evt_i) begin
         if (taken_i && taken_cnt_q != 16'hFFFF)
            taken_cnt_q <= taken_cnt_q + 16'd1;
         else if (!taken_i && not_taken_cnt_q != 16'hFFFF)
            not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
      end
   end

   assign taken_cnt_o     = taken_cnt_q;
   assign not_taken_cnt_o = not_taken_cnt_q;

endmodule

// File: rtl/branch_seq_ctrl.sv
// Fetch + conditional-branch control sequencer (T0..T6).
// Optional feature macro: BRANCH_STATS_EN adds taken/not-taken counters.
module branch_seq_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter logic [4:0] BR_OPCODE    = cpu_ctrl_pkg::BR_OPCODE,
   parameter int         MEM_WAIT_MAX = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        mem_ready,
   input  logic [31:0] ir,
   input  logic        con_q,
   output logic        pc_out,
   output logic        mar_in,
   output logic        inc_pc,
   output logic        z_in,
   output logic        zlo_out,
   output logic        pc_in,
   output logic        mdr_in,
   output logic        mem_read,
   output logic        mdr_out,
   output logic        ir_in,
   output logic        gra,
   output logic        r_out,
   output logic        con_in,
   output logic        y_in,
   output logic        c_out,
   output logic        alu_add,
   output logic        busy,
   output logic        done,
   output logic        taken,
   output logic        err
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0] taken_cnt,
   output logic [15:0] not_taken_cnt
`endif
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       taken_q, taken_d;

   // only the opcode field is decoded here; condition bits feed the CON logic
   logic       ir_unused;
   assign ir_unused = ^ir[26:0];

   // state, wait counter and branch result registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         taken_q <= taken_d;
      end
   end

   // next-state: memory wait in T1, opcode check in T3, branch resolve in T6
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      taken_d = taken_q;
      unique case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_T0;
            taken_d = 1'b0;
         end
         ST_T0: begin
            state_d = ST_T1;
            wait_d  = '0;
         end
         ST_T1: begin
            if (mem_ready)               state_d = ST_T2;
            else if (wait_q == WAIT_LAST) state_d = ST_ERR;
            else                         wait_d  = wait_q + 8'd1;
         end
         ST_T2: state_d = ST_T3;
         ST_T3: state_d = (ir[31:27] == BR_OPCODE) ? ST_T4 : ST_ERR;
         ST_T4: state_d = ST_T5;
         ST_T5: state_d = ST_T6;
         ST_T6: begin
            state_d = ST_DONE;
            taken_d = con_q;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // strobe decode from the state register; T6 PC reload gated by CON
   always_comb begin
      pc_out   = 1'b0;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      z_in     = 1'b0;
      zlo_out  = 1'b0;
      pc_in    = 1'b0;
      mdr_in   = 1'b0;
      mem_read = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      gra      = 1'b0;
      r_out    = 1'b0;
      con_in   = 1'b0;
      y_in     = 1'b0;
      c_out    = 1'b0;
      alu_add  = 1'b0;
      unique case (state_q)
         ST_T0: begin
            pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
         end
         ST_T1: begin
            zlo_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
         end
         ST_T2: begin
            mdr_out = 1'b1; ir_in = 1'b1;
         end
         ST_T3: begin
            gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
         end
         ST_T4: begin
            pc_out = 1'b1; y_in = 1'b1;
         end
         ST_T5: begin
            c_out = 1'b1; alu_add = 1'b1; z_in = 1'b1;
         end
         ST_T6: begin
            zlo_out = con_q; pc_in = con_q;
         end
         default: ;
      endcase
   end

   assign busy  = (state_q != ST_IDLE);
   assign done  = (state_q == ST_DONE);
   assign err   = (state_q == ST_ERR);
   assign taken = taken_q;

`ifdef BRANCH_STATS_EN
   branch_stat_counters u_stats (
      .clock_i         (clock),
      .reset_n_i       (reset_n),
      .evt_i           (state_q == ST_T6),
      .taken_i         (con_q),
      .taken_cnt_o     (taken_cnt),
      .not_taken_cnt_o (not_taken_cnt)
   );
`endif

endmodule
